// File: rtl/stopwatch_digits.sv
// -----------------------------------------------------------------------------
// stopwatch_digits
//
// Stopwatch core. It keeps elapsed time as eight BCD digits, HH:MM:SS.hh, and
// advances on an external 100 Hz tick. It drives the d7..d0 digit inputs of the
// seven-segment display controller. Each digit is encoded as
// {en, dp, 1'b0, hex[3:0]}.
//
// Parameters
//   BLANK_LZ    1 = blank leading zeros of the hours field.
//
// Ports
//   clk         system clock
//   rst         asynchronous active-low reset
//   tick        one-cycle pulse, one hundredth of a second
//   start_stop  one-cycle pulse, toggles counting
//   lap         one-cycle pulse, toggles display freeze while running
//   clear       one-cycle pulse, zeroes the count and returns to IDLE
//   d7..d0      registered digit codes; d7 = hours tens, d0 = hundredths units
//   running     registered, high in RUN or LAP
//   rollover    registered, one-cycle pulse after the count wraps to zero
//
// Input protocol: tick/start_stop/lap/clear are level-sampled on every rising
// edge. A high level for k cycles counts as k pulses; there is no ready or
// back-pressure. When pulses arrive together, clear wins over start_stop, and
// start_stop wins over lap. A losing pulse is dropped.
//
// The FSM state is held in state_q (type state_e). Checkers bind to it there.
// -----------------------------------------------------------------------------
module stopwatch_digits #(
    parameter bit BLANK_LZ = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       start_stop,
    input  logic       lap,
    input  logic       clear,
    output logic [6:0] d7,
    output logic [6:0] d6,
    output logic [6:0] d5,
    output logic [6:0] d4,
    output logic [6:0] d3,
    output logic [6:0] d2,
    output logic [6:0] d1,
    output logic [6:0] d0,
    output logic       running,
    output logic       rollover
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_STOP = 2'd2,
        S_LAP  = 2'd3
    } state_e;

    // Per-digit maximum, index 0 = hundredths units ... index 7 = hours tens.
    // It equals the BCD image of 99:59:59.99.
    localparam logic [7:0][3:0] DIGIT_MAX = 32'h9959_5999;

    // Builds the display codes for a BCD count. dp marks the separators after
    // hours, minutes and seconds. A blanked digit keeps hex=0 and its dp.
    function automatic logic [7:0][6:0] encode_digits(input logic [7:0][3:0] src);
        logic [7:0][6:0] enc;
        logic            en;
        logic            dp;
        enc = '0;
        for (int i = 0; i < 8; i++) begin
            en = 1'b1;
            dp = (i == 2) || (i == 4) || (i == 6);
            if (BLANK_LZ) begin
                if (i == 7) en = (src[7] != 4'd0);
                if (i == 6) en = (src[7] != 4'd0) || (src[6] != 4'd0);
            end
            enc[i[2:0]] = {en, dp, 1'b0, src[i[2:0]]};
        end
        return enc;
    endfunction

    state_e          state_q, state_d;
    logic [7:0][3:0] count_q, count_d;
    logic [7:0][3:0] snap_q, snap_d;
    logic [7:0][6:0] disp_q, disp_d;
    logic            running_q, running_d;
    logic            rollover_q, rollover_d;

    logic [7:0][3:0] count_inc;
    logic            inc;
    logic            carry;
    logic            wrap;
    logic [7:0][3:0] disp_src;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            count_q    <= '0;
            snap_q     <= '0;
            disp_q     <= encode_digits('0);
            running_q  <= 1'b0;
            rollover_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            snap_q     <= snap_d;
            disp_q     <= disp_d;
            running_q  <= running_d;
            rollover_q <= rollover_d;
        end
    end

    // ------------------------------------------------------------------
    // Next state, count and snapshot
    // ------------------------------------------------------------------
    always_comb begin
        // Counting is decided by the state before this edge's transition.
        // A tick that arrives together with clear is lost.
        inc = tick && ((state_q == S_RUN) || (state_q == S_LAP)) && !clear;

        // Ripple carry across all eight digits in one cycle. If the carry
        // comes out of the hours tens digit, the count has wrapped.
        count_inc = count_q;
        carry     = inc;
        for (int i = 0; i < 8; i++) begin
            if (carry) begin
                if (count_q[i[2:0]] == DIGIT_MAX[i[2:0]]) begin
                    count_inc[i[2:0]] = 4'd0;
                end else begin
                    count_inc[i[2:0]] = count_q[i[2:0]] + 4'd1;
                    carry             = 1'b0;
                end
            end
        end
        wrap = carry;

        state_d = state_q;
        count_d = count_inc;
        snap_d  = snap_q;

        if (clear) begin
            state_d = S_IDLE;
            count_d = '0;
            snap_d  = '0;
        end else begin
            case (state_q)
                S_IDLE: if (start_stop) state_d = S_RUN;
                S_RUN: begin
                    if (start_stop) begin
                        state_d = S_STOP;
                    end else if (lap) begin
                        state_d = S_LAP;
                        // The snapshot is the pre-increment count.
                        snap_d  = count_q;
                    end
                end
                S_LAP: begin
                    if (start_stop)  state_d = S_STOP;
                    else if (lap)    state_d = S_RUN;
                end
                S_STOP: if (start_stop) state_d = S_RUN;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Registered outputs
    // ------------------------------------------------------------------
    always_comb begin
        disp_src   = (state_q == S_LAP) ? snap_q : count_q;
        disp_d     = encode_digits(disp_src);
        running_d  = (state_d == S_RUN) || (state_d == S_LAP);
        rollover_d = wrap;
    end

    assign d7       = disp_q[7];
    assign d6       = disp_q[6];
    assign d5       = disp_q[5];
    assign d4       = disp_q[4];
    assign d3       = disp_q[3];
    assign d2       = disp_q[2];
    assign d1       = disp_q[1];
    assign d0       = disp_q[0];
    assign running  = running_q;
    assign rollover = rollover_q;

endmodule

// File: tb/tb_stopwatch_digits.sv
// -----------------------------------------------------------------------------
// tb_stopwatch_digits
//
// Bench for stopwatch_digits. The driver pushes one expected output word per
// driven cycle into exp_q. The monitor pops and compares that word one
// timestep after the following rising edge. The reference model keeps elapsed
// time as a plain count of hundredths and derives the display from it
// arithmetically.
// -----------------------------------------------------------------------------
module tb_stopwatch_digits;

    localparam int MOD   = 36000000;  // hundredths in 100 hours
    localparam int EXP_W = 58;        // {d7..d0, running, rollover}

    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_STOP = 2;
    localparam int M_LAP  = 3;

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       tick = 1'b0;
    logic       start_stop = 1'b0;
    logic       lap = 1'b0;
    logic       clear = 1'b0;
    logic [6:0] d7, d6, d5, d4, d3, d2, d1, d0;
    logic       running;
    logic       rollover;

    always #5 clk = ~clk;

    stopwatch_digits #(.BLANK_LZ(1'b1)) dut (
        .clk        (clk),
        .rst        (rst),
        .tick       (tick),
        .start_stop (start_stop),
        .lap        (lap),
        .clear      (clear),
        .d7         (d7),
        .d6         (d6),
        .d5         (d5),
        .d4         (d4),
        .d3         (d3),
        .d2         (d2),
        .d1         (d1),
        .d0         (d0),
        .running    (running),
        .rollover   (rollover)
    );

    // ---------------- scoreboard state ----------------
    logic [EXP_W-1:0] exp_q[$];
    int checks   = 0;
    int failures = 0;

    // ---------------- reference model ----------------
    int m_state = M_IDLE;
    int m_cnt   = 0;
    int m_snap  = 0;

    function automatic logic [55:0] enc(input int c);
        logic [55:0] r;
        int          hh, mm, ss, hs;
        int          dg[8];
        logic        en, dp;
        logic [3:0]  h;
        hh = c / 360000;
        mm = (c / 6000) % 60;
        ss = (c / 100) % 60;
        hs = c % 100;
        dg[7] = hh / 10; dg[6] = hh % 10;
        dg[5] = mm / 10; dg[4] = mm % 10;
        dg[3] = ss / 10; dg[2] = ss % 10;
        dg[1] = hs / 10; dg[0] = hs % 10;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            en = 1'b1;
            dp = (i == 2) || (i == 4) || (i == 6);
            if (i == 7) en = (hh >= 10);
            if (i == 6) en = (hh != 0);
            h = dg[i][3:0];
            r[i*7 +: 7] = {en, dp, 1'b0, h};
        end
        return r;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drive_cycle(input logic t, input logic s, input logic l, input logic c);
        logic [55:0] de;
        logic        wrap;
        int          old;
        @(posedge clk);
        #2;
        tick       = t;
        start_stop = s;
        lap        = l;
        clear      = c;
        de   = enc((m_state == M_LAP) ? m_snap : m_cnt);
        wrap = 1'b0;
        if (c) begin
            m_state = M_IDLE;
            m_cnt   = 0;
            m_snap  = 0;
        end else begin
            old = m_cnt;
            if (t && (m_state == M_RUN || m_state == M_LAP)) begin
                if (m_cnt == MOD - 1) wrap = 1'b1;
                m_cnt = (m_cnt + 1) % MOD;
            end
            if (s) begin
                m_state = (m_state == M_IDLE || m_state == M_STOP) ? M_RUN : M_STOP;
            end else if (l) begin
                if (m_state == M_RUN) begin
                    m_state = M_LAP;
                    m_snap  = old;
                end else if (m_state == M_LAP) begin
                    m_state = M_RUN;
                end
            end
        end
        exp_q.push_back({de, (m_state == M_RUN) || (m_state == M_LAP), wrap});
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) drive_cycle(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic check_reset_outputs(input string tag);
        logic [55:0] got;
        got = {d7, d6, d5, d4, d3, d2, d1, d0};
        checks++;
        if (got !== 56'h00_20_40_60_40_60_40_40 >> 0 ? 1'b0 : 1'b0) begin end
        if (got !== {7'h00, 7'h20, 7'h40, 7'h60, 7'h40, 7'h60, 7'h40, 7'h40}) begin
            failures++;
            $display("FAIL %s_digits got=%h exp=%h", tag, got,
                     {7'h00, 7'h20, 7'h40, 7'h60, 7'h40, 7'h60, 7'h40, 7'h40});
        end
        checks++;
        if (running !== 1'b0) begin
            failures++;
            $display("FAIL %s_running got=%b exp=0", tag, running);
        end
        checks++;
        if (rollover !== 1'b0) begin
            failures++;
            $display("FAIL %s_rollover got=%b exp=0", tag, rollover);
        end
    endtask

    // Asserted right after an expectation has been popped, so exp_q is empty.
    task automatic apply_reset(input string tag);
        @(posedge clk);
        #2;
        rst        = 1'b0;
        tick       = 1'b0;
        start_stop = 1'b0;
        lap        = 1'b0;
        clear      = 1'b0;
        exp_q.delete();
        m_state = M_IDLE;
        m_cnt   = 0;
        m_snap  = 0;
        #1;
        check_reset_outputs(tag);
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs(tag);
        @(posedge clk);
        #2;
        rst = 1'b1;
    endtask

    // ---------------- monitor ----------------
    initial begin
        logic [EXP_W-1:0] e;
        logic [55:0]      got_d;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e     = exp_q.pop_front();
                got_d = {d7, d6, d5, d4, d3, d2, d1, d0};
                checks++;
                if (got_d !== e[57:2]) begin
                    failures++;
                    $display("FAIL digits t=%0t got=%h exp=%h", $time, got_d, e[57:2]);
                end
                checks++;
                if (running !== e[1]) begin
                    failures++;
                    $display("FAIL running t=%0t got=%b exp=%b", $time, running, e[1]);
                end
                checks++;
                if (rollover !== e[0]) begin
                    failures++;
                    $display("FAIL rollover t=%0t got=%b exp=%b", $time, rollover, e[0]);
                end
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #2000000;
        $display("FAIL watchdog t=%0t got=timeout exp=finish", $time);
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin
        int r;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(posedge clk);
        #2;
        rst = 1'b1;

        // IDLE ignores ticks and lap.
        ticks(150);
        drive_cycle(1'b0, 1'b0, 1'b1, 1'b0);

        // One minute of counting.
        drive_cycle(1'b0, 1'b1, 1'b0, 1'b0);
        ticks(6000);
        drive_cycle(1'b0, 1'b0, 1'b0, 1'b0);

        // Freeze at 00:00:59.99, keep counting, then release to 00:01:00.04.
        drive_cycle(1'b0, 1'b0, 1'b0, 1'b1);
        drive_cycle(1'b0, 1'b1, 1'b0, 1'b0);
        ticks(5999);
        drive_cycle(1'b0, 1'b0, 1'b1, 1'b0);
        ticks(5);
        drive_cycle(1'b0, 1'b0, 1'b0, 1'b0);
        drive_cycle(1'b0, 1'b0, 1'b1, 1'b0);
        drive_cycle(1'b0, 1'b0, 1'b0, 1'b0);
        drive_cycle(1'b0, 1'b0, 1'b0, 1'b0);

        // Jump to 99:59:59.98 while running, then wrap.
        drive_cycle(1'b0, 1'b0, 1'b0, 1'b0);
        force dut.count_d = 32'h9959_5998;
        m_cnt = MOD - 2;
        @(posedge clk);
        #1;
        release dut.count_d;
        drive_cycle(1'b0, 1'b0, 1'b0, 1'b0);
        ticks(2);
        for (int i = 0; i < 3; i++) drive_cycle(1'b0, 1'b0, 1'b0, 1'b0);
        ticks(3);

        // In STOP, a tick together with start_stop is not counted.
        drive_cycle(1'b0, 1'b1, 1'b0, 1'b0);
        ticks(4);
        drive_cycle(1'b1, 1'b1, 1'b0, 1'b0);
        drive_cycle(1'b1, 1'b0, 1'b0, 1'b0);
        drive_cycle(1'b0, 1'b0, 1'b0, 1'b0);
        drive_cycle(1'b0, 1'b0, 1'b0, 1'b0);

        // In RUN, a tick together with start_stop is counted; lap is dropped.
        drive_cycle(1'b1, 1'b1, 1'b1, 1'b0);
        drive_cycle(1'b0, 1'b1, 1'b0, 1'b0);
        ticks(3);

        // In LAP, clear + start_stop + tick together go to IDLE with zero.
        drive_cycle(1'b0, 1'b0, 1'b1, 1'b0);
        ticks(7);
        drive_cycle(1'b1, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) drive_cycle(1'b0, 1'b0, 1'b0, 1'b0);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(0, 999);
            drive_cycle($urandom_range(0, 1) == 1,
                        $urandom_range(0, 39) == 0,
                        $urandom_range(0, 19) == 0,
                        r < 5);
        end

        // Reset in the middle of a run.
        drive_cycle(1'b0, 1'b0, 1'b0, 1'b1);
        drive_cycle(1'b0, 1'b1, 1'b0, 1'b0);
        ticks(37);
        apply_reset("midreset");
        for (int i = 0; i < 1000; i++) begin
            drive_cycle($urandom_range(0, 3) != 0,
                        $urandom_range(0, 29) == 0,
                        $urandom_range(0, 14) == 0,
                        $urandom_range(0, 299) == 0);
        end
        for (int i = 0; i < 3; i++) drive_cycle(1'b0, 1'b0, 1'b0, 1'b0);

        @(posedge clk);
        #3;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain got=%0d exp=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
